melody_sequencer: RTL and testbench

Score-driven note sequencer that produces the 13-bit `slow_rate` half-period word consumed by the speaker PWM stage. It holds a writable 32-entry score (note code plus duration in beats), and on `start` steps through it. It drives the matching half-period count for each note, inserts a short silence between notes, and stops or loops at an end marker. Runs on the same 1 MHz `clk` as the PWM stage.

---
 rtl/melody_sequencer_if.sv | 12 +
 rtl/melody_sequencer.sv | 141 ++++++++++++++
 tb/tb_melody_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// rtl/melody_sequencer_if.sv - control and score-write bus for the melody sequencer
interface melody_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output start, stop, loop, wr_en, wr_addr, wr_data);
  modport slave  (input  start, stop, loop, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - score-driven note sequencer producing the PWM half-period word
module melody_sequencer #(
  parameter int TICKS_PER_BEAT = 125000,
  parameter int GAP_TICKS      = 10000
) (
  input  logic                clk,
  input  logic                rst,
  melody_sequencer_if.slave   bus,
  output logic [12:0]         slow_rate,
  output logic                playing,
  output logic                done,
  output logic [4:0]          note_index
);

  localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [7:0]    score [32];
  logic [7:0]    entry;
  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    beat_cnt;

  // Half-period counts, round(500000/f)-1, C4..C5; anything else is a rest
  function automatic logic [12:0] note_rate(input logic [3:0] code);
    case (code)
      4'd1:    note_rate = 13'd1910;
      4'd2:    note_rate = 13'd1803;
      4'd3:    note_rate = 13'd1702;
      4'd4:    note_rate = 13'd1606;
      4'd5:    note_rate = 13'd1516;
      4'd6:    note_rate = 13'd1431;
      4'd7:    note_rate = 13'd1350;
      4'd8:    note_rate = 13'd1275;
      4'd9:    note_rate = 13'd1203;
      4'd10:   note_rate = 13'd1135;
      4'd11:   note_rate = 13'd1072;
      4'd12:   note_rate = 13'd1011;
      4'd13:   note_rate = 13'd955;
      default: note_rate = 13'd0;
    endcase
  endfunction

  // Asynchronous read: a write landing on the same edge as a FETCH is seen only afterwards
  assign entry = score[note_index];

  // Score storage, writable in every state and untouched by reset
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      score[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Playback FSM; stop and rst take priority over everything, done is a single-cycle pulse
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state      <= ST_IDLE;
      slow_rate  <= '0;
      playing    <= 1'b0;
      note_index <= '0;
      tick_cnt   <= '0;
      beat_cnt   <= '0;
    end else if (bus.stop) begin
      state      <= ST_IDLE;
      slow_rate  <= '0;
      playing    <= 1'b0;
      note_index <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          slow_rate  <= '0;
          note_index <= '0;
          if (bus.start) begin
            state   <= ST_FETCH;
            playing <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (entry[3:0] == 4'd0) begin
            // End marker: restart from entry 0 or finish
            note_index <= '0;
            if (bus.loop) begin
              state <= ST_FETCH;
            end else begin
              state   <= ST_IDLE;
              playing <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            slow_rate <= note_rate(entry[7:4]);
            beat_cnt  <= entry[3:0];
            tick_cnt  <= '0;
            state     <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (beat_cnt == 4'd1) begin
              slow_rate <= '0;
              state     <= ST_GAP;
            end else begin
              beat_cnt <= beat_cnt - 4'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: begin
          if (tick_cnt == GAP_LAST) begin
            tick_cnt <= '0;
            if (note_index == 5'd31) begin
              // Running off the last entry ends the score like a marker does
              note_index <= '0;
              if (bus.loop) begin
                state <= ST_FETCH;
              end else begin
                state   <= ST_IDLE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              note_index <= note_index + 5'd1;
              state      <= ST_FETCH;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - directed self-checking bench for melody_sequencer
module tb_melody_sequencer;
  localparam int TPB   = 10;
  localparam int GAP_T = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] slow_rate;
  logic        playing;
  logic        done;
  logic [4:0]  note_index;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  melody_sequencer_if bus ();

  melody_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP_T)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .slow_rate  (slow_rate),
    .playing    (playing),
    .done       (done),
    .note_index (note_index)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(addr);
    bus.wr_data = 8'(data);
    step();
    bus.wr_en   = 1'b0;
  endtask

  // start is high during cycle 0; returns in cycle 1 (FETCH)
  task automatic start_play();
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic expect_span(input string tag, input int from, input int to,
                             input int rate, input int play, input int idx);
    for (int c = from; c <= to; c++) begin
      run_to(c);
      check({tag, "_rate"}, slow_rate, rate);
      check({tag, "_playing"}, playing, play);
      check({tag, "_index"}, note_index, idx);
      check({tag, "_done"}, done, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // reset state
    step();
    step();
    check("rst_rate", slow_rate, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);
    check("rst_index", note_index, 0);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) wr(a, 8'h00);

    // single A4 note, two beats
    wr(0, 8'hA2);
    wr(1, 8'h00);
    start_play();
    expect_span("t1_fetch", 1, 1, 0, 1, 0);
    expect_span("t1_tone", 2, 21, 1135, 1, 0);
    expect_span("t1_gap", 22, 23, 0, 1, 0);
    expect_span("t1_endfetch", 24, 24, 0, 1, 1);
    run_to(25);
    check("t1_done", done, 1);
    check("t1_playing_low", playing, 0);
    check("t1_index_clr", note_index, 0);
    run_to(26);
    check("t1_done_pulse", done, 0);

    // C4 then C5
    wr(0, 8'h11);
    wr(1, 8'hD1);
    wr(2, 8'h00);
    start_play();
    expect_span("t2_fetch0", 1, 1, 0, 1, 0);
    expect_span("t2_c4", 2, 11, 1910, 1, 0);
    expect_span("t2_gap0", 12, 13, 0, 1, 0);
    expect_span("t2_fetch1", 14, 14, 0, 1, 1);
    expect_span("t2_c5", 15, 24, 955, 1, 1);
    expect_span("t2_gap1", 25, 26, 0, 1, 1);
    expect_span("t2_fetch2", 27, 27, 0, 1, 2);
    run_to(28);
    check("t2_done", done, 1);
    check("t2_playing_low", playing, 0);

    // looping E4: silence between repeats is gap + marker fetch + entry-0 fetch
    wr(0, 8'h51);
    wr(1, 8'h00);
    bus.loop = 1'b1;
    start_play();
    expect_span("t3_fetch0", 1, 1, 0, 1, 0);
    expect_span("t3_e4_a", 2, 11, 1516, 1, 0);
    expect_span("t3_gap_a", 12, 13, 0, 1, 0);
    expect_span("t3_mark_a", 14, 14, 0, 1, 1);
    expect_span("t3_refetch_a", 15, 15, 0, 1, 0);
    expect_span("t3_e4_b", 16, 25, 1516, 1, 0);
    expect_span("t3_gap_b", 26, 27, 0, 1, 0);
    expect_span("t3_mark_b", 28, 28, 0, 1, 1);
    expect_span("t3_refetch_b", 29, 29, 0, 1, 0);
    expect_span("t3_e4_c", 30, 35, 1516, 1, 0);

    // stop mid-PLAY
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("stop_rate", slow_rate, 0);
    check("stop_playing", playing, 0);
    check("stop_index", note_index, 0);
    check("stop_done", done, 0);
    step();
    check("stop_done_after", done, 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    check("startstop_playing_a", playing, 0);
    step();
    check("startstop_playing_b", playing, 0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    step();
    check("startstop_playing_c", playing, 0);
    check("startstop_rate", slow_rate, 0);

    // rest codes, three beats each, do not end the score
    wr(0, 8'hE3);
    wr(1, 8'h03);
    wr(2, 8'h00);
    start_play();
    expect_span("t5_rest0", 1, 33, 0, 1, 0);
    expect_span("t5_rest1", 34, 66, 0, 1, 1);
    expect_span("t5_fetch2", 67, 67, 0, 1, 2);
    run_to(68);
    check("t5_done", done, 1);

    // write entry 1 while entry 0 plays; write entry 2 during its own FETCH
    wr(0, 8'hA1);
    wr(1, 8'h00);
    wr(2, 8'h00);
    wr(3, 8'h00);
    start_play();
    run_to(5);
    wr(1, 8'h81);
    expect_span("t6_a4", 6, 11, 1135, 1, 0);
    expect_span("t6_gap0", 12, 13, 0, 1, 0);
    expect_span("t6_fetch1", 14, 14, 0, 1, 1);
    expect_span("t6_g4", 15, 24, 1275, 1, 1);
    expect_span("t6_gap1", 25, 26, 0, 1, 1);
    run_to(27);
    check("t6_fetch2_index", note_index, 2);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 8'hC1;
    step();
    bus.wr_en = 1'b0;
    check("t6_old_data_done", done, 1);
    check("t6_old_data_playing", playing, 0);

    // reset mid-PLAY keeps the score
    start_play();
    run_to(5);
    rst = 1'b1;
    step();
    check("t7_rst_rate", slow_rate, 0);
    check("t7_rst_playing", playing, 0);
    check("t7_rst_index", note_index, 0);
    check("t7_rst_done", done, 0);
    rst = 1'b0;
    step();
    check("t7_rst_idle", playing, 0);
    start_play();
    expect_span("t7_a4", 2, 11, 1135, 1, 0);
    expect_span("t7_g4", 15, 24, 1275, 1, 1);
    expect_span("t7_b4", 28, 37, 1011, 1, 2);
    expect_span("t7_gap2", 38, 39, 0, 1, 2);
    expect_span("t7_fetch3", 40, 40, 0, 1, 3);
    run_to(41);
    check("t7_done", done, 1);

    // full 32-entry score with no marker ends at the 31 -> 0 wrap
    for (int a = 0; a < 32; a++) wr(a, 8'h11);
    start_play();
    expect_span("t8_fetch31", 404, 404, 0, 1, 31);
    expect_span("t8_play31", 405, 405, 1910, 1, 31);
    while (!done && cyc < 600) step();
    check("t8_done_cycle", cyc, 417);
    check("t8_done", done, 1);
    check("t8_playing_low", playing, 0);
    check("t8_index", note_index, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
